// File: rtl/cacheline_adaptor_pkg.sv
// Shared type packages for the cache line adaptor.
//   rv32i_types : rv32i_word, the 32-bit address type used on the address ports.
//   cache_types : line/burst geometry constants and the adaptor FSM state enum.

package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage : rv32i_types

package cache_types;
    localparam int s_line   = 256;
    localparam int s_burst  = 64;
    localparam int beats    = s_line / s_burst;
    // Byte-offset bits cleared to line-align the memory address.
    localparam int offset_w = $clog2(s_line / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;
endpackage : cache_types

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the cache's single-transfer 256-bit line interface to a 4-beat,
//   64-bit memory burst. One request (fill or write-back) runs one burst.
//   A completed request is signalled with a single-cycle resp_o.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   line_i     : write-back line from the cache
//   line_o     : assembled fill line (buffer contents)
//   address_i  : cache request address
//   read_i     : cache line-fill request
//   write_i    : cache write-back request (wins over read_i)
//   resp_o     : request-complete pulse
//   burst_i    : memory read beat
//   burst_o    : memory write beat
//   address_o  : line-aligned memory address
//   read_o     : burst read request to memory
//   write_o    : burst write request to memory
//   resp_i     : memory beat strobe
// All outputs are decoded from registered state only.

module cacheline_adaptor
    import rv32i_types::*;
    import cache_types::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  rv32i_word           address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,

    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output rv32i_word           address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam logic [1:0] LAST_BEAT = 2'(beats - 1);

    adaptor_state_t     state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [s_line-1:0]  buf_q, buf_d;
    rv32i_word          addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    buf_d   = line_i;
                    addr_d  = address_i;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    buf_d[s_burst*cnt_q +: s_burst] = burst_i;
                    // The counter only wraps 3->0 on the exit beat.
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                // Requests are not sampled here; the cache sees resp_o first.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign address_o = {addr_q[31:offset_w], {offset_w{1'b0}}};
    assign burst_o   = buf_q[s_burst*cnt_q +: s_burst];
    assign line_o    = buf_q;

endmodule : cacheline_adaptor

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts the L1 cache's single-transfer 256-bit line interface into the 4-beat, 64-bit burst protocol of physical memory. Sits directly downstream of the cache datapath and control: it accepts a line fill (read) or write-back (write) request from the cache and runs one burst to memory. For a read, it assembles four beats into a line and returns it to the cache with a one-cycle response.

## Interface
Parameters:
- s_line, 256, cache line width in bits
- s_burst, 64, memory beat width in bits
- beats, 4, beats per line (s_line / s_burst)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- line_i  input  256  write-back line from the cache (pmem_wdata side)
- line_o  output  256  assembled fill line to the cache (pmem_rdata side)
- address_i  input  32  cache request address
- read_i  input  1  cache requests a line fill
- write_i  input  1  cache requests a write-back
- resp_o  output  1  one-cycle pulse: request complete
- burst_i  input  64  memory read beat
- burst_o  output  64  memory write beat
- address_o  output  32  line-aligned memory address
- read_o  output  1  burst read request to memory
- write_o  output  1  burst write request to memory
- resp_i  input  1  memory beat valid/accepted strobe

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter `cnt`.
- IDLE:
  - write_i=1: latch line_i into the buffer and address_i into the address register, set cnt=0, go to WRITE.
  - Otherwise read_i=1: latch address, set cnt=0, go to READ.
  - write_i has priority if both are asserted.
- address_o = {addr_reg[31:5], 5'b0}. It is held constant from the cycle after acceptance through DONE.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: buffer[64*cnt +: 64] <= burst_i and cnt increments.
  - The beat with cnt=3 and resp_i=1 moves the FSM to DONE.
  - resp_i=0 cycles stall without advancing; gaps between beats are legal.
- WRITE:
  - write_o=1; burst_o = buffer[64*cnt +: 64].
  - Each cycle with resp_i=1 advances cnt. The resp_i beat at cnt=3 moves the FSM to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then unconditional return to IDLE.
  - read_i and write_i are ignored in DONE.
- line_o is driven from the buffer continuously. It is valid from DONE of a read and holds until the next accepted request overwrites the buffer.
- resp_i outside READ or WRITE is ignored.
- Counter wrap (3 to 0) occurs only on the exit transition.

## Timing
- Reset: state=IDLE, cnt=0, buffer=0, address register=0. This gives read_o=write_o=resp_o=0, address_o=0, burst_o=0, line_o=0.
- Reset asserted mid-burst aborts immediately. Memory sees read_o/write_o drop in the same cycle. No resp_o is issued.
- Request sampled at edge t. read_o/write_o are high from cycle t+1.
- With resp_i high for 4 consecutive cycles starting at t+1: resp_o is high in cycle t+5. A back-to-back request is accepted no earlier than edge t+6 (IDLE).
- Total latency = 2 + (number of cycles until the 4th resp_i).
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Shared `cache_types` package holds:
  - s_line, s_burst and beats constants
  - the state enum `adaptor_state_t` {IDLE, READ, WRITE, DONE}
- The `rv32i_word` type from `rv32i_types` is used for the address ports.
- Single module; no sub-module is natural. The buffer, counter and FSM are inline.

## Test plan
- Read fill, address_i=32'h0000_1234; memory returns beats 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444… on 4 consecutive cycles. Required: address_o=32'h0000_1220, line_o={4444…,3333…,2222…,1111…}, resp_o pulses once, 5 cycles after acceptance.
- Write-back, line_i=256'h(beat3..beat0 distinct patterns); memory strobes resp_i with one idle cycle between each beat. Required: burst_o=beat0..beat3 in order, each held through its gap; write_o held until the 4th beat; single resp_o pulse.
- Simultaneous read_i=write_i=1 in IDLE. Required: WRITE is entered, read_o stays 0, write_o=1.
- rst asserted after 2 read beats. Required: read_o=0 and line_o=0 immediately, no resp_o. The next read completes normally with fresh data.
- Back-to-back: read_i held high through DONE. Required: exactly one resp_o, then a new read_o starting 1 cycle after IDLE is re-entered.
- Spurious resp_i in IDLE with burst_i=64'hDEAD_BEEF_DEAD_BEEF. Required: no state change, line_o unchanged.
